// File: rtl/pru_cmd_pkg.sv
// pru_cmd_pkg: draw-command struct, packer FSM states and word packing helpers
package pru_cmd_pkg;

    localparam int COL_LSB   = 0;
    localparam int ROW_LSB   = 9;
    localparam int COLOR_LSB = 19;
    localparam int SHAPE_LSB = 21;
    localparam int HR_LSB    = 0;
    localparam int WIDTH_LSB = 9;
    localparam int SUB_BIT   = 21;
    localparam int CLOAD_BIT = 22;

    typedef struct packed {
        logic       color_load;
        logic       subtract;
        logic [8:0] height_radius;
        logic [9:0] width;
        logic [1:0] shape;
        logic [1:0] color;
        logic [9:0] row;
        logic [8:0] col;
    } pru_cmd_t;

    typedef enum logic [1:0] {IDLE, SEND0, SEND1} pru_pack_state_t;

    function automatic logic [31:0] pack_word0(input pru_cmd_t c);
        logic [31:0] w;
        w = '0;
        w[COL_LSB +: 9]   = c.col;
        w[ROW_LSB +: 10]  = c.row;
        w[COLOR_LSB +: 2] = c.color;
        w[SHAPE_LSB +: 2] = c.shape;
        return w;
    endfunction

    function automatic logic [31:0] pack_word1(input pru_cmd_t c);
        logic [31:0] w;
        w = '0;
        w[HR_LSB +: 9]     = c.height_radius;
        w[WIDTH_LSB +: 10] = c.width;
        w[SUB_BIT]         = c.subtract;
        w[CLOAD_BIT]       = c.color_load;
        return w;
    endfunction

endpackage

// File: rtl/pru_cmd_packer_if.sv
// pru_cmd_packer_if: command input handshake plus two-word write/data/ack bus
interface pru_cmd_packer_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [8:0]  cmd_col;
    logic [9:0]  cmd_row;
    logic [1:0]  cmd_color;
    logic [1:0]  cmd_shape;
    logic [9:0]  cmd_width;
    logic [8:0]  cmd_height_radius;
    logic        cmd_subtract;
    logic        cmd_color_load;
    logic        write;
    logic [31:0] data;
    logic        ack;

    modport master (
        input  cmd_valid, cmd_col, cmd_row, cmd_color, cmd_shape, cmd_width,
               cmd_height_radius, cmd_subtract, cmd_color_load, ack,
        output cmd_ready, write, data
    );

    modport slave (
        output cmd_valid, cmd_col, cmd_row, cmd_color, cmd_shape, cmd_width,
               cmd_height_radius, cmd_subtract, cmd_color_load, ack,
        input  cmd_ready, write, data
    );

endinterface

// File: rtl/pru_cmd_fifo.sv
// pru_cmd_fifo: synchronous FIFO of draw commands with occupancy count
module pru_cmd_fifo
    import pru_cmd_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  logic     pop,
    input  pru_cmd_t wdata,
    output pru_cmd_t rdata,
    output logic     full,
    output logic     empty,
    output logic [AW:0] level
);

    pru_cmd_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = level == (AW+1)'(DEPTH);
    assign empty   = level == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset; occupancy decides what is valid
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/pru_cmd_packer.sv
// pru_cmd_packer: buffers draw commands and sends each as word0 then word1; PRU_PACK_TIMEOUT_EN adds a sticky ack timeout flag
module pru_cmd_packer
    import pru_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    pru_cmd_packer_if.master              bus,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef PRU_PACK_TIMEOUT_EN
    ,
    output logic                          timeout_err
`endif
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || ACK_TIMEOUT < 1) begin : g_bad_param
        $error("pru_cmd_packer: FIFO_DEPTH must be a power of two >= 2 and ACK_TIMEOUT >= 1");
    end

    pru_pack_state_t state, state_d;
    pru_cmd_t        in_cmd, head, cur_q;
    logic            full, empty, pop, write_d;
    logic [31:0]     data_d;

    assign in_cmd = '{
        color_load:    bus.cmd_color_load,
        subtract:      bus.cmd_subtract,
        height_radius: bus.cmd_height_radius,
        width:         bus.cmd_width,
        shape:         bus.cmd_shape,
        color:         bus.cmd_color,
        row:           bus.cmd_row,
        col:           bus.cmd_col
    };

    assign bus.cmd_ready = rst_n && !full;
    assign busy          = state != IDLE || !empty;

    pru_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.cmd_valid && bus.cmd_ready),
        .pop   (pop),
        .wdata (in_cmd),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    // Next state and next output word; SEND1 chains straight into the next word0 when work is queued
    always_comb begin
        state_d = state;
        write_d = bus.write;
        data_d  = bus.data;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    write_d = 1'b1;
                    data_d  = pack_word0(head);
                    state_d = SEND0;
                end
            end
            SEND0: begin
                if (bus.ack) begin
                    data_d  = pack_word1(cur_q);
                    state_d = SEND1;
                end
            end
            SEND1: begin
                if (bus.ack) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        data_d  = pack_word0(head);
                        state_d = SEND0;
                    end else begin
                        write_d = 1'b0;
                        data_d  = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs and the command currently on the bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bus.write <= 1'b0;
            bus.data  <= '0;
            cur_q     <= '0;
        end else begin
            state     <= state_d;
            bus.write <= write_d;
            bus.data  <= data_d;
            if (pop) cur_q <= head;
        end
    end

`ifdef PRU_PACK_TIMEOUT_EN
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    logic [TW-1:0] to_cnt;
    logic          to_flag;

    assign timeout_err = to_flag || to_cnt == TW'(ACK_TIMEOUT);

    // Count consecutive unacknowledged write cycles; the flag is sticky and never aborts the transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt  <= '0;
            to_flag <= 1'b0;
        end else begin
            if (!bus.write || (bus.write && bus.ack == 1'b1)) to_cnt <= '0;
            else if (to_cnt != TW'(ACK_TIMEOUT)) to_cnt <= to_cnt + TW'(1);
            if (to_cnt == TW'(ACK_TIMEOUT)) to_flag <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pru_cmd_packer.sv
// tb_pru_cmd_packer: directed checks of command buffering and two-word serialisation
module tb_pru_cmd_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy;
    logic [2:0]  fifo_level;
    logic [31:0] d;
    int          n_pass = 0;
    int          n_tot = 0;
`ifdef PRU_PACK_TIMEOUT_EN
    logic        timeout_err;
`endif

    logic [31:0] tw0 [5] = '{32'h0000_0001, 32'h0000_0200, 32'h0018_0000, 32'h0040_0000, 32'h0060_01FF};
    logic [31:0] tw1 [5] = '{32'h0000_0002, 32'h0000_0200, 32'h0020_0000, 32'h0040_0000, 32'h0007_FFFF};

    always #5 clk = ~clk;

    pru_cmd_packer_if bus();

    pru_cmd_packer #(.FIFO_DEPTH(4), .ACK_TIMEOUT(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .busy       (busy),
        .fifo_level (fifo_level)
`ifdef PRU_PACK_TIMEOUT_EN
        ,
        .timeout_err(timeout_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [8:0] col, input logic [9:0] row, input logic [1:0] color,
                         input logic [1:0] shape, input logic [9:0] width, input logic [8:0] hr,
                         input logic sub, input logic cl);
        bus.cmd_col           = col;
        bus.cmd_row           = row;
        bus.cmd_color         = color;
        bus.cmd_shape         = shape;
        bus.cmd_width         = width;
        bus.cmd_height_radius = hr;
        bus.cmd_subtract      = sub;
        bus.cmd_color_load    = cl;
    endtask

    task automatic drive_tab(input int k);
        case (k)
            0: drive(9'h001, 10'h000, 2'd0, 2'd0, 10'h000, 9'h002, 1'b0, 1'b0);
            1: drive(9'h000, 10'h001, 2'd0, 2'd0, 10'h001, 9'h000, 1'b0, 1'b0);
            2: drive(9'h000, 10'h000, 2'd3, 2'd0, 10'h000, 9'h000, 1'b1, 1'b0);
            3: drive(9'h000, 10'h000, 2'd0, 2'd2, 10'h000, 9'h000, 1'b0, 1'b1);
            default: drive(9'h1FF, 10'h000, 2'd0, 2'd3, 10'h3FF, 9'h1FF, 1'b0, 1'b0);
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.ack       = 1'b0;
        drive(9'h0, 10'h0, 2'd0, 2'd0, 10'h0, 9'h0, 1'b0, 1'b0);
        cyc(2);
        check("rst_ready", bus.cmd_ready, 0);
        check("rst_write", bus.write, 0);
        check("rst_data", bus.data, 0);
        check("rst_busy", busy, 0);
        check("rst_level", fifo_level, 0);
        rst_n = 1'b1;
        #1;
        check("rel_ready", bus.cmd_ready, 1);

        bus.ack = 1'b1;
        drive(9'h1A5, 10'h2F3, 2'd2, 2'd1, 10'h140, 9'h0C8, 1'b1, 1'b0);
        bus.cmd_valid = 1'b1;
        cyc();
        bus.cmd_valid = 1'b0;
        check("s1_lat_write", bus.write, 0);
        check("s1_level", fifo_level, 1);
        check("s1_busy", busy, 1);
        cyc();
        check("s1_w0_write", bus.write, 1);
        check("s1_w0", bus.data, 32'h0035_E7A5);
        cyc();
        check("s1_w1_write", bus.write, 1);
        check("s1_w1", bus.data, 32'h0022_80C8);
        cyc();
        check("s1_end_write", bus.write, 0);
        check("s1_end_data", bus.data, 0);
        check("s1_end_busy", busy, 0);

        bus.ack = 1'b0;
        bus.cmd_valid = 1'b1;
        cyc();
        bus.cmd_valid = 1'b0;
        cyc();
        check("s2_w0", bus.data, 32'h0035_E7A5);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("s2_hold_write", bus.write, 1);
            check("s2_hold_data", bus.data, 32'h0035_E7A5);
        end
        bus.ack = 1'b1;
        cyc();
        check("s2_w1", bus.data, 32'h0022_80C8);
        cyc();
        check("s2_end_write", bus.write, 0);

        bus.ack = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_tab(k);
            bus.cmd_valid = 1'b1;
            cyc();
        end
        drive(9'h0AA, 10'h155, 2'd1, 2'd1, 10'h2AA, 9'h155, 1'b1, 1'b1);
        check("s3_level_full", fifo_level, 4);
        check("s3_ready_full", bus.cmd_ready, 0);
        check("s3_head_out", bus.data, tw0[0]);
        cyc(2);
        check("s3_stall_level", fifo_level, 4);
        bus.cmd_valid = 1'b0;
        bus.ack = 1'b1;
        for (int j = 0; j < 10; j++) begin
            check("s3_stream_write", bus.write, 1);
            check("s3_stream_data", bus.data, (j % 2 == 0) ? tw0[j / 2] : tw1[j / 2]);
            cyc();
        end
        check("s3_end_write", bus.write, 0);
        check("s3_end_level", fifo_level, 0);

        drive(9'h1FF, 10'h3FF, 2'd3, 2'd3, 10'h3FF, 9'h1FF, 1'b1, 1'b1);
        bus.cmd_valid = 1'b1;
        cyc();
        bus.cmd_valid = 1'b0;
        cyc();
        check("s4_w0", bus.data, 32'h007F_FFFF);
        cyc();
        d = bus.data;
        check("s4_w1", d, 32'h0067_FFFF);
        check("s4_w1_hi_zero", d[31:23], 0);
        check("s4_w1_gap_zero", d[20:19], 0);
        cyc();
        check("s4_end_write", bus.write, 0);

        bus.ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_tab(k);
            bus.cmd_valid = 1'b1;
            cyc();
        end
        bus.cmd_valid = 1'b0;
        bus.ack = 1'b1;
        cyc();
        bus.ack = 1'b0;
        check("s5_in_send1", bus.data, tw1[0]);
        check("s5_queued", fifo_level, 2);
        rst_n = 1'b0;
        #1;
        check("s5_rst_write", bus.write, 0);
        check("s5_rst_data", bus.data, 0);
        check("s5_rst_level", fifo_level, 0);
        check("s5_rst_busy", busy, 0);
        cyc();
        rst_n = 1'b1;
        bus.ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("s5_no_write", bus.write, 0);
        end

`ifdef PRU_PACK_TIMEOUT_EN
        check("to_clear", timeout_err, 0);
        bus.ack = 1'b0;
        drive_tab(0);
        bus.cmd_valid = 1'b1;
        cyc();
        bus.cmd_valid = 1'b0;
        cyc();
        check("to_w0", bus.data, tw0[0]);
        cyc(7);
        check("to_not_yet", timeout_err, 0);
        cyc();
        check("to_set", timeout_err, 1);
        bus.ack = 1'b1;
        cyc();
        check("to_w1", bus.data, tw1[0]);
        cyc();
        check("to_end_write", bus.write, 0);
        check("to_sticky", timeout_err, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/pru_cmd_packer.md
Name: pru_cmd_packer

Overview:
- Initiator side of the PRU two-word draw-command write interface.
- Accepts complete draw commands (shape, position, size, color, flags) from the host-side/control logic through a valid/ready port. Buffers them in a small FIFO.
- Serialises each command into two 32-bit words over the `write`/`data`/`ack` handshake consumed by the PRU preprocessor: geometry word (word0) first, then size/flags word (word1).

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of two, >= 2.
- ACK_TIMEOUT, 255, cycles of unacknowledged `write` before `timeout_err` sets (optional feature only).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present on `cmd_*` inputs
- cmd_ready  out  1  FIFO can accept a command
- cmd_col  in  9  start col (rectangle) / center col (circle)
- cmd_row  in  10  start row / center row
- cmd_color  in  2  color value
- cmd_shape  in  2  shape select (00 rectangle, 01 circle, others passed through)
- cmd_width  in  10  rectangle width
- cmd_height_radius  in  9  rectangle height / circle radius
- cmd_subtract  in  1  subtract flag
- cmd_color_load  in  1  color load flag
- write  out  1  word valid toward preprocessor
- data  out  32  word being transferred
- ack  in  1  word accepted; only 1'b1 counts, and z/x/0 are all treated as not-accepted
- busy  out  1  FSM not IDLE or FIFO non-empty
- fifo_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, immediate):
  - `write`=0, `data`=0, `cmd_ready`=1 after reset releases (0 while held), `busy`=0, `fifo_level`=0.
  - FIFO emptied; FSM goes to IDLE.
  - Reset mid-transfer abandons the command with no further words.
- Word packing; all unlisted bits are 0:
  - word0: [8:0]=col, [18:9]=row, [20:19]=color, [22:21]=shape.
  - word1: [8:0]=height_radius, [18:9]=width, [21]=subtract, [22]=color_load; [20:19]=0.
- Input side:
  - A push occurs when `cmd_valid && cmd_ready`.
  - `cmd_ready` = !full.
  - When the FIFO is full, a same-cycle pop does not enable a push; `cmd_ready` rises the cycle after the pop.
- FSM states IDLE, SEND0, SEND1; `write` and `data` are registered.
  - IDLE: if FIFO non-empty, pop the head, load `data`=word0, set `write`=1, go to SEND0.
  - SEND0: hold `write`/`data` stable until `ack`==1. On that cycle, load `data`=word1 and go to SEND1; `write` stays 1.
  - SEND1: hold until `ack`==1.
    - If the FIFO is non-empty: pop, load the next word0, go to SEND0, `write` stays 1 (no bubble).
    - Otherwise: `write`=0, `data`=0, go to IDLE.
- Latency: a command pushed in cycle N into an empty, idle block produces `write`=1 with word0 in cycle N+2.
- Throughput: 2 cycles per command with `ack` continuously high.
- Words are never reordered or split across commands; word1 always immediately follows its own word0.
- `ack` while `write`=0 is ignored.

Optional Feature:
- Macro PRU_PACK_TIMEOUT_EN.
- Defined:
  - Adds output `timeout_err` (1 bit, reset 0) and an internal counter.
  - The counter increments each cycle `write`=1 && `ack`!=1, and clears on any accepted word or when `write`=0.
  - When the counter reaches ACK_TIMEOUT, `timeout_err` sets and stays set until reset.
  - The transfer is not aborted; the block keeps waiting.
- Undefined: no port, no counter, no behavioural difference otherwise.

Decomposition:
- Package pru_cmd_pkg holds:
  - typedef pru_cmd_t, a packed struct of all command fields.
  - State enum pru_pack_state_t.
  - localparams for word bit positions: COL_LSB=0, ROW_LSB=9, COLOR_LSB=19, SHAPE_LSB=21, HR_LSB=0, WIDTH_LSB=9, SUB_BIT=21, CLOAD_BIT=22.
- Sub-module pru_cmd_fifo is a synchronous FIFO of pru_cmd_t with push/pop/full/empty/level.
- The packer FSM lives in the top module.

Test Plan:
- Single command, `ack` tied 1, inputs col=9'h1A5, row=10'h2F3, color=2, shape=1, hr=9'h0C8, width=10'h140, sub=1, cload=0 -> `data`=32'h0035E7A5 then 32'h002280C8 on consecutive cycles, then `write`=0.
- Same command with `ack` held low 5 cycles on word0 -> `write`/`data` constant for those 5 cycles; word1 appears only the cycle after `ack`=1.
- `ack` low, push 5 commands -> the first is in the output register, `fifo_level`=4, `cmd_ready`=0, and the 6th command is stalled. Then `ack` tied 1 -> 10 consecutive `write` cycles, in order, no gaps.
- All fields all-ones -> word0=32'h007FFFFF, word1=32'h0067FFFF; bits 20:19 and 31:23 of word1 are 0.
- `rst_n` low during SEND1 with 2 commands queued -> `write`=0, `data`=0, `fifo_level`=0 immediately; no `write` after release.
- With PRU_PACK_TIMEOUT_EN and ACK_TIMEOUT=8, `ack` low -> `timeout_err`=1 after 8 unacknowledged cycles; it remains 1 after `ack` arrives and the transfer completes normally.
